dmem_lsu: RTL

Load/store unit that sits directly upstream of the data memory and is its only client. It accepts byte, halfword and word load/store requests from the pipeline MEM stage and always issues word-aligned 32-bit accesses to the data memory. Sub-word stores are done as read-modify-write, because the memory only writes full words. Loads are lane-extracted and sign- or zero-extended. Byte order is big-endian: byte offset 0 maps to bits [31:24].

---
 rtl/dmem_lsu.sv | 139 +++++++++++++
 1 files changed

// File: rtl/dmem_lsu.sv
// Load/store unit in front of a word-only data memory: sub-word stores are done as
// read-modify-write, loads are lane-extracted and extended. Big-endian byte lanes.
module dmem_lsu #(
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] DMEM_address,
    output logic [31:0] DMEM_data_in,
    output logic        DMEM_mem_write,
    output logic        DMEM_mem_read,
    input  logic [31:0] DMEM_data_out
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        write_q;
    logic        uns_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic        req_err;
    logic [1:0]  off;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_val;
    logic [31:0] merge_val;

    always_comb begin
        req_err = (req_size == 2'b11)
               || (req_size == 2'b01 && req_addr[0])
               || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
               || (req_addr >= 32'(MEM_BYTES));
    end

    always_comb begin
        off = addr_q[1:0];
        case (off)
            2'd0:    byte_lane = DMEM_data_out[31:24];
            2'd1:    byte_lane = DMEM_data_out[23:16];
            2'd2:    byte_lane = DMEM_data_out[15:8];
            default: byte_lane = DMEM_data_out[7:0];
        endcase
        half_lane = off[1] ? DMEM_data_out[15:0] : DMEM_data_out[31:16];

        case (size_q)
            2'b00:   load_val = uns_q ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            2'b01:   load_val = uns_q ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
            default: load_val = DMEM_data_out;
        endcase

        merge_val = DMEM_data_out;
        if (size_q == 2'b00) begin
            case (off)
                2'd0:    merge_val[31:24] = wdata_q[7:0];
                2'd1:    merge_val[23:16] = wdata_q[7:0];
                2'd2:    merge_val[15:8]  = wdata_q[7:0];
                default: merge_val[7:0]   = wdata_q[7:0];
            endcase
        end else if (off[1]) begin
            merge_val[15:0] = wdata_q[15:0];
        end else begin
            merge_val[31:16] = wdata_q[15:0];
        end
    end

    // wdata_q doubles as the RMW word buffer: it holds the merged word once RD completes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        size_q  <= req_size;
                        write_q <= req_write;
                        uns_q   <= req_unsigned;
                        wdata_q <= req_wdata;
                        err_q   <= req_err;
                        if (req_err) begin
                            rdata_q <= '0;
                            state_q <= RESP;
                        end else if (!req_write || req_size != 2'b10) begin
                            state_q <= RD;
                        end else begin
                            state_q <= WR;
                        end
                    end
                end
                RD: begin
                    if (write_q) begin
                        wdata_q <= merge_val;
                        state_q <= WR;
                    end else begin
                        rdata_q <= load_val;
                        state_q <= RESP;
                    end
                end
                WR: begin
                    rdata_q <= '0;
                    state_q <= RESP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready      = (state_q == IDLE);
    assign resp_valid     = (state_q == RESP);
    assign resp_err       = (state_q == RESP) && err_q;
    assign resp_rdata     = rdata_q;
    assign DMEM_address   = {addr_q[31:2], 2'b00};
    assign DMEM_data_in   = wdata_q;
    assign DMEM_mem_read  = (state_q == RD);
    assign DMEM_mem_write = (state_q == WR) && rst_n;

endmodule
